// File: rtl/regfile_dump_tx.sv
// regfile_dump_tx
// Dumps the architectural register file over a UART TX line (8N1, LSB
// first, idle high). One rising edge on start sends the SYNC_BYTE frame
// followed by x0..x(NUM_REGS-1). Each register goes out as four
// big-endian bytes (bits 31:24 first). The block reads through the
// register file's spare combinational read port and never writes it.
//
// Timing: let E be the clock edge that first samples start high while
// start_q is low. SYNC starts its start bit on E. done is high for the
// single cycle that begins at edge
//   E + 10*CLKS_PER_BIT*(1+4*NUM_REGS) + 2*NUM_REGS,
// so the fixed overhead is 0 cycles. Each register adds two cycles (LOAD
// and NEXT) on top of its 40 bit times. tx idles high during those two
// cycles. The four bytes of one word are sent back to back with no gap.
//
// Handshake: start is a level. Only a 0->1 transition seen in IDLE begins
// a dump. Edges seen while a dump is in progress are dropped, not queued.
// busy is high from the cycle after the accepted edge. It falls in the
// same cycle that done pulses.

module regfile_dump_tx #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          NUM_REGS     = 32,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]      ADDR_LAST = 5'(NUM_REGS - 1);
  // Frame bit positions: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  localparam logic [3:0]      STOP_IDX  = 4'd9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SYNC = 3'd1,
    LOAD = 3'd2,
    BYTE = 3'd3,
    NEXT = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state;
  logic             start_q;
  logic [CNT_W-1:0] baud_cnt;
  logic [3:0]       bit_idx;
  logic [1:0]       byte_idx;
  logic [31:0]      word_q;

  logic [7:0]       word_byte;
  logic [7:0]       cur_byte;
  logic [9:0]       frame;
  logic [3:0]       bit_nxt;
  logic             bit_end;
  logic             start_edge;

  // Select the byte on the wire and build the full 10-bit frame around it.
  always_comb begin
    word_byte = word_q[31:24];
    unique case (byte_idx)
      2'd0: word_byte = word_q[31:24];
      2'd1: word_byte = word_q[23:16];
      2'd2: word_byte = word_q[15:8];
      2'd3: word_byte = word_q[7:0];
      default: word_byte = word_q[31:24];
    endcase
    cur_byte   = (state == SYNC) ? SYNC_BYTE : word_byte;
    frame      = {1'b1, cur_byte, 1'b0};
    bit_nxt    = bit_idx + 4'd1;
    bit_end    = (baud_cnt == CNT_LAST);
    start_edge = start & ~start_q;
  end

  // Dump sequencer, UART bit timing and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      start_q  <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= 4'd0;
      byte_idx <= 2'd0;
      word_q   <= 32'd0;
      rd_addr  <= 5'd0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start_q <= start;
      done    <= 1'b0;

      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start_edge) begin
            // The start bit goes out on the same edge that accepts start.
            state    <= SYNC;
            busy     <= 1'b1;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= 4'd0;
            byte_idx <= 2'd0;
          end
        end

        SYNC, BYTE: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
              bit_idx <= 4'd0;
              if (state == SYNC) begin
                state   <= LOAD;
                rd_addr <= 5'd0;
                tx      <= 1'b1;
              end else if (byte_idx != 2'd3) begin
                // Next byte of the same word starts immediately.
                byte_idx <= byte_idx + 2'd1;
                tx       <= 1'b0;
              end else begin
                state <= NEXT;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_nxt;
              tx      <= frame[bit_nxt];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        LOAD: begin
          // The only cycle in which rd_data is captured.
          word_q   <= rd_data;
          byte_idx <= 2'd0;
          bit_idx  <= 4'd0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= BYTE;
        end

        NEXT: begin
          tx <= 1'b1;
          if (rd_addr == ADDR_LAST) begin
            state <= FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            rd_addr <= rd_addr + 5'd1;
            state   <= LOAD;
          end
        end

        FIN: begin
          tx    <= 1'b1;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_tx.sv
// Bench for regfile_dump_tx with CLKS_PER_BIT=4 and NUM_REGS=3.
// A UART receiver decodes tx into bytes. A reference model builds the
// expected byte stream straight from the register-file contents.
module tb_regfile_dump_tx;

  localparam int CPB    = 4;
  localparam int NREGS  = 3;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int BUDGET = 2000;
  localparam int DUMP_CYCLES = 10 * CPB * (1 + 4 * NREGS) + 2 * NREGS;

  logic        clk;
  logic        reset;
  logic        start;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        tx;
  logic        busy;
  logic        done;

  logic [31:0] rf [32];
  assign rd_data = rf[rd_addr];

  regfile_dump_tx #(
    .CLKS_PER_BIT (CPB),
    .NUM_REGS     (NREGS),
    .SYNC_BYTE    (SYNC)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .tx      (tx),
    .busy    (busy),
    .done    (done)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         frame_starts[$];
  int         n_cmp  = 0;
  int         n_fail = 0;
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         busy_drop = 0;
  logic       busy_at_done = 1'b0;
  bit         dump_active = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- UART receiver / monitor ----------------
  bit         rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [9:0] rx_bits;
  logic       cur_level;
  bit         glitch;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      rx_active   = 1'b0;
      dump_active = 1'b0;
    end else begin
      if (!rx_active && tx == 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
        glitch    = 1'b0;
        rx_bits   = '0;
        frame_starts.push_back(cyc);
      end
      if (rx_active) begin
        if (rx_cnt % CPB == 0) begin
          cur_level = tx;
          rx_bits[rx_cnt / CPB] = tx;
        end else if (tx !== cur_level) begin
          glitch = 1'b1;
        end
        rx_cnt++;
        if (rx_cnt == 10 * CPB) begin
          check("frame_shape", {29'd0, glitch, rx_bits[9], rx_bits[0]}, 32'h2);
          got_q.push_back(rx_bits[8:1]);
          rx_active = 1'b0;
        end
      end
      if (dump_active && !done && !busy) busy_drop++;
      if (done) begin
        done_cnt++;
        done_cyc     = cyc;
        busy_at_done = busy;
        dump_active  = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic build_expected();
    exp_q.delete();
    exp_q.push_back(SYNC);
    for (int r = 0; r < NREGS; r++)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(8'((rf[r] >> (24 - 8 * b)) & 32'hFF));
  endtask

  // mode: 0 = 1-cycle pulse, 1 = held high through the dump,
  //       2 = pulse plus a second pulse mid-dump,
  //       3 = pulse, and x1 is overwritten once its first byte is on the wire
  task automatic run_dump(input int mode, input int exp_dones, input int exp_frames);
    int  base_done;
    int  e_cyc;
    int  k;
    bit  changed;
    build_expected();
    got_q.delete();
    frame_starts.delete();
    base_done = done_cnt;
    busy_drop = 0;
    changed   = 1'b0;
    @(negedge clk);
    start = 1'b1;
    e_cyc = cyc + 1;
    @(negedge clk);
    dump_active = 1'b1;
    if (mode != 1) start = 1'b0;
    k = 0;
    while (done_cnt == base_done && k < BUDGET) begin
      @(negedge clk);
      k++;
      if (mode == 2 && k == 100) start = 1'b1;
      if (mode == 2 && k == 101) start = 1'b0;
      if (mode == 3 && !changed && frame_starts.size() >= 6) begin
        rf[1]   = 32'hFFFF_FFFF;
        changed = 1'b1;
      end
    end
    check("done_timeout", {31'd0, (k >= BUDGET)}, 32'd0);
    check("done_latency", 32'(done_cyc - e_cyc), 32'(DUMP_CYCLES));
    check("busy_at_done", {31'd0, busy_at_done}, 32'd0);
    check("busy_held", 32'(busy_drop), 32'd0);
    check("rd_addr_hold", {27'd0, rd_addr}, 32'(NREGS - 1));
    repeat (60) @(negedge clk);
    check("done_count", 32'(done_cnt - base_done), 32'(exp_dones));
    check("busy_idle", {31'd0, busy}, 32'd0);
    check("frame_count", 32'(got_q.size()), 32'(exp_frames));
    if (frame_starts.size() > 0)
      check("first_frame_start", 32'(frame_starts[0]), 32'(e_cyc));
    for (int i = 0; i < exp_q.size(); i++)
      check("byte", (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD, {24'd0, exp_q[i]});
    begin
      int gap_bad = 0;
      for (int i = 2; i < frame_starts.size(); i++)
        if (i % 4 != 1 && frame_starts[i] - frame_starts[i-1] != 10 * CPB) gap_bad++;
      check("contiguous_bytes", 32'(gap_bad), 32'd0);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] x0;
    logic [31:0] x1;
    logic [31:0] x2;
    int          mode;
    int          exp_dones;
    int          exp_frames;
  } vec_t;

  vec_t vecs[5];

  initial begin
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    vecs[0] = '{32'h0, 32'h0000_000C, 32'h0000_000D, 0, 1, 13};
    vecs[1] = '{32'h0, 32'h0000_000C, 32'h0000_000D, 1, 1, 13};
    vecs[2] = '{32'h0, 32'h0000_000C, 32'h0000_000D, 2, 1, 13};
    vecs[3] = '{32'h0, 32'h0000_000C, 32'h0000_000D, 0, 1, 13};
    vecs[4] = '{32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFF, 0, 1, 13};

    // Asynchronous reset before any clock edge.
    #1 reset = 1'b1;
    #1;
    check("rst_tx",      {31'd0, tx},      32'd1);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_tx", {31'd0, tx}, 32'd1);

    // Table-driven dumps.
    for (int v = 0; v < 5; v++) begin
      rf[0] = vecs[v].x0;
      rf[1] = vecs[v].x1;
      rf[2] = vecs[v].x2;
      run_dump(vecs[v].mode, vecs[v].exp_dones, vecs[v].exp_frames);
    end

    // Randomized register contents.
    for (int n = 0; n < 3; n++) begin
      for (int r = 0; r < NREGS; r++) rf[r] = $urandom;
      run_dump(0, 1, 13);
    end

    // x1 overwritten after its LOAD: the original value must still go out.
    rf[0] = 32'h0;
    rf[1] = 32'h0000_000C;
    rf[2] = 32'h0000_000D;
    run_dump(3, 1, 13);
    rf[1] = 32'h0000_000C;

    // Reset in the middle of byte 2 of x1.
    begin
      int base_done;
      int k;
      base_done = done_cnt;
      frame_starts.delete();
      got_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (frame_starts.size() < 8 && k < BUDGET) begin
        @(negedge clk);
        k++;
      end
      check("mid_frame_reach", {31'd0, (k >= BUDGET)}, 32'd0);
      repeat (5) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_tx",      {31'd0, tx},      32'd1);
      check("mid_rst_busy",    {31'd0, busy},    32'd0);
      check("mid_rst_done",    {31'd0, done},    32'd0);
      check("mid_rst_rd_addr", {27'd0, rd_addr}, 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (300) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt - base_done), 32'd0);
      check("mid_rst_idle_tx", {31'd0, tx}, 32'd1);
    end
    run_dump(0, 1, 13);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
